// File: rtl/resp_pkg.sv
// Shared types and message ROM for the verdict response transmitter.
// Both 5-byte messages are packed with byte 0 in the low bits.
package resp_pkg;

  typedef enum logic {MSG_ACK, MSG_NAK} msg_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} seq_state_t;

  localparam int MSG_LEN = 5;

  typedef logic [2:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(MSG_LEN - 1);

  // NOTE: the ROM is pure constant data, so there is no storage here to reset.
  localparam logic [8*MSG_LEN-1:0] ACK_ROM = {8'h0A, 8'h0D, 8'h4B, 8'h43, 8'h41};
  localparam logic [8*MSG_LEN-1:0] NAK_ROM = {8'h0A, 8'h0D, 8'h4B, 8'h41, 8'h4E};

  function automatic logic [7:0] msg_byte(input msg_t kind, input byte_idx_t idx);
    logic [8*MSG_LEN-1:0] rom;
    rom = (kind == MSG_NAK) ? NAK_ROM : ACK_ROM;
    return rom[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_resp_tx_if.sv
// Verdict inputs and serial/status outputs of the response transmitter.
interface uart_resp_tx_if;
  logic accept;
  logic reject;
  logic tx;
  logic busy;
  logic overflow;

  modport master (output accept, output reject, input tx, input busy, input overflow);
  modport slave  (input accept, input reject, output tx, output busy, output overflow);
endinterface

// File: rtl/uart_tx.sv
// Generic 8N1 byte transmitter. done fires one cycle before the stop bit ends so a
// following start can be accepted in the last stop cycle, giving back-to-back frames.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    STOP_BIT = 4'd9;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end, frame_end, load;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    data_d = data_q;
    tx_d   = tx_q;
    busy_d = busy_q;

    bit_end   = busy_q && (cnt_q == CNT_LAST);
    frame_end = bit_end && (bit_q == STOP_BIT);
    // Busy except for the final stop cycle, where a new frame may chain on.
    load      = start && (!busy_q || frame_end);

    if (load) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      bit_d  = '0;
      data_d = data;
      tx_d   = 1'b0;
    end else if (frame_end) begin
      busy_d = 1'b0;
      cnt_d  = '0;
      tx_d   = 1'b1;
    end else if (bit_end) begin
      cnt_d = '0;
      bit_d = bit_q + 4'd1;
      tx_d  = (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      data_q <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      data_q <= data_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = busy_q && (bit_q == STOP_BIT) && (cnt_q == CNT_DONE);

endmodule

// File: rtl/uart_resp_tx.sv
// Turns accept/reject pulses into "ACK\r\n" / "NAK\r\n" on a UART line, with a
// one-deep pending slot in front of a per-message byte sequencer.
module uart_resp_tx
  import resp_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_resp_tx_if.slave  bus
);

  seq_state_t state_q, state_d;
  msg_t       msg_q, msg_d;
  byte_idx_t  idx_q, idx_d;
  logic       pend_q, pend_d;
  msg_t       pend_msg_q, pend_msg_d;
  logic       ovf_q, ovf_d;

  logic       event_in;
  logic       byte_start;
  logic       byte_done;
  logic [7:0] byte_data;
  logic       utx_busy;
  logic       utx_tx;

  // Pending slot: the pop and a load can never coincide, since a load needs it empty.
  always_comb begin
    pend_d     = pend_q;
    pend_msg_d = pend_msg_q;
    ovf_d      = 1'b0;
    event_in   = bus.accept || bus.reject;

    if ((state_q == IDLE) && pend_q) begin
      pend_d = 1'b0;
    end
    if (event_in) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_msg_d = bus.reject ? MSG_NAK : MSG_ACK;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          msg_d   = pend_msg_q;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (byte_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_start = (state_q == SEND);
    byte_data  = msg_byte(msg_q, idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      msg_q      <= MSG_ACK;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      pend_msg_q <= MSG_ACK;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_q      <= msg_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_msg_q <= pend_msg_d;
      ovf_q      <= ovf_d;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (byte_data),
    .tx    (utx_tx),
    .busy  (utx_busy),
    .done  (byte_done)
  );

  // The sequencer returns to IDLE during the last stop cycle, so the byte
  // transmitter's own busy covers that final cycle.
  assign bus.tx       = utx_tx;
  assign bus.busy     = (state_q != IDLE) || utx_busy;
  assign bus.overflow = ovf_q;

endmodule
